// File: rtl/screen_scaler_bridge.sv
// screen_scaler_bridge: converts a row-major 1bpp CHIP-8 framebuffer into page-format
// bytes (8 vertical pixels per byte, bit0 = top row) with integer pixel replication,
// and serves them to a display driver through a registered read port.
// Optional build macro SCREEN_DOUBLE_BUFFER_EN: two RAM banks, swapped at frame_done,
// so the display never observes a partially converted frame.
module screen_scaler_bridge #(
    parameter int unsigned SRC_W = 64,
    parameter int unsigned SRC_H = 32,
    parameter int unsigned SCALE = 2,
    localparam int unsigned OUT_W  = SRC_W * SCALE,
    localparam int unsigned PAGES  = (SRC_H * SCALE) / 8,
    localparam int unsigned CB     = SRC_W / 8,
    localparam int unsigned SRC_AW = (CB * SRC_H > 1) ? $clog2(CB * SRC_H) : 1,
    localparam int unsigned PG_W   = (PAGES > 1) ? $clog2(PAGES) : 1,
    localparam int unsigned COL_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_tick_60hz,
    input  logic              i_read,
    input  logic [PG_W-1:0]   i_row_idx,
    input  logic [COL_W-1:0]  i_column_idx,
    output logic [7:0]        o_data,
    output logic              o_ack,
    output logic              o_frame_done,
    output logic              o_scr_busy,
    output logic              o_scr_read,
    output logic [SRC_AW-1:0] o_scr_read_idx,
    input  logic [7:0]        i_scr_read_byte,
    input  logic              i_scr_read_ack
);

    // Source rows gathered per page block, and counter widths.
    localparam int unsigned RPB   = (SCALE == 0) ? 8 : 8 / SCALE;
    localparam int unsigned CB_W  = (CB > 1) ? $clog2(CB) : 1;
    localparam int unsigned K_W   = (RPB > 1) ? $clog2(RPB) : 1;
    localparam int unsigned J_W   = (8 * SCALE > 1) ? $clog2(8 * SCALE) : 1;
    localparam int unsigned DEPTH = PAGES * OUT_W;

`ifdef SCREEN_DOUBLE_BUFFER_EN
    localparam int unsigned BANKS = 2;
`else
    localparam int unsigned BANKS = 1;
`endif

    localparam int unsigned MEM_AW = (BANKS * DEPTH > 1) ? $clog2(BANKS * DEPTH) : 1;

    // Elaboration-time sanity checks on scale factor and geometry.
    if (SCALE != 1 && SCALE != 2) begin : g_bad_scale
        $error("screen_scaler_bridge: SCALE must be 1 or 2");
    end
    if (SRC_W == 0 || SRC_H == 0 || (SRC_W % 8) != 0 || ((SRC_H * SCALE) % 8) != 0)
    begin : g_bad_geom
        $error("screen_scaler_bridge: SRC_W and SRC_H*SCALE must be non-zero multiples of 8");
    end

    typedef enum logic [1:0] {StRead, StWrite, StIdle} state_e;

    state_e           r_state;
    logic [PG_W-1:0]  r_page;
    logic [CB_W-1:0]  r_cb;
    logic [K_W-1:0]   r_k;
    logic [J_W-1:0]   r_j;
    logic             r_draw_pending;
    logic             r_frame_done;
    logic [7:0]       r_rect [RPB];
    logic [7:0]       r_mem [BANKS*DEPTH];
    logic [7:0]       r_data;
    logic             r_ack;

    logic             w_front;
    logic             w_back;
    logic [2:0]       w_bit_sel;
    logic [7:0]       w_wr_byte;
    logic [MEM_AW-1:0] w_wr_addr;
    logic [MEM_AW-1:0] w_rd_addr;

`ifdef SCREEN_DOUBLE_BUFFER_EN
    logic r_front;

    // Front bank flips at the end of the frame_done cycle, so a read in that cycle
    // still sees the previous frame.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_front <= 1'b0;
        end else if (r_frame_done) begin
            r_front <= ~r_front;
        end
    end

    assign w_front = r_front;
    assign w_back  = ~r_front;
`else
    assign w_front = 1'b0;
    assign w_back  = 1'b0;
`endif

    assign o_scr_read     = (r_state == StRead) && !i_scr_read_ack;
    assign o_scr_read_idx = SRC_AW'((32'(r_page) * RPB + 32'(r_k)) * CB + 32'(r_cb));
    assign o_scr_busy     = (r_state != StIdle);
    assign o_frame_done   = r_frame_done;
    assign o_data         = r_data;
    assign o_ack          = r_ack;

    assign w_bit_sel = 3'(7 - 32'(r_j) / SCALE);
    assign w_wr_addr = MEM_AW'(32'(w_back) * DEPTH + 32'(r_page) * OUT_W
                               + 32'(r_cb) * 8 * SCALE + 32'(r_j));
    assign w_rd_addr = MEM_AW'(32'(w_front) * DEPTH + 32'(i_row_idx) * OUT_W
                               + 32'(i_column_idx));

    // Build one output column byte: bit b comes from source row b/SCALE of the block.
    always_comb begin
        w_wr_byte = '0;
        for (int unsigned b = 0; b < 8; b++) begin
            w_wr_byte[b] = r_rect[K_W'(b / SCALE)][w_bit_sel];
        end
    end

    // Conversion FSM: gather RPB source bytes, emit 8*SCALE column bytes, repeat per block.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state        <= StRead;
            r_page         <= '0;
            r_cb           <= '0;
            r_k            <= '0;
            r_j            <= '0;
            r_draw_pending <= 1'b0;
            r_frame_done   <= 1'b0;
            for (int unsigned i = 0; i < RPB; i++) begin
                r_rect[i] <= '0;
            end
        end else begin
            r_frame_done <= 1'b0;
            if (i_tick_60hz) begin
                r_draw_pending <= 1'b1;
            end
            case (r_state)
                StRead: begin
                    if (i_scr_read_ack) begin
                        r_rect[r_k] <= i_scr_read_byte;
                        if (r_k == K_W'(RPB - 1)) begin
                            r_k     <= '0;
                            r_state <= StWrite;
                        end else begin
                            r_k <= r_k + 1'b1;
                        end
                    end
                end
                StWrite: begin
                    if (r_j == J_W'(8 * SCALE - 1)) begin
                        r_j <= '0;
                        if (r_cb == CB_W'(CB - 1)) begin
                            r_cb <= '0;
                            if (r_page == PG_W'(PAGES - 1)) begin
                                r_page       <= '0;
                                r_state      <= StIdle;
                                r_frame_done <= 1'b1;
                            end else begin
                                r_page  <= r_page + 1'b1;
                                r_state <= StRead;
                            end
                        end else begin
                            r_cb    <= r_cb + 1'b1;
                            r_state <= StRead;
                        end
                    end else begin
                        r_j <= r_j + 1'b1;
                    end
                end
                StIdle: begin
                    if (r_draw_pending) begin
                        // A tick landing in this same cycle keeps the request alive.
                        if (!i_tick_60hz) begin
                            r_draw_pending <= 1'b0;
                        end
                        r_page  <= '0;
                        r_cb    <= '0;
                        r_k     <= '0;
                        r_j     <= '0;
                        r_state <= StRead;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Page RAM write port; contents deliberately survive reset.
    always_ff @(posedge i_clk) begin
        if (r_state == StWrite) begin
            r_mem[w_wr_addr] <= w_wr_byte;
        end
    end

    // Display read port: one-cycle registered read, accepted in every state.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ack  <= 1'b0;
            r_data <= '0;
        end else begin
            r_ack <= i_read;
            if (i_read) begin
                r_data <= r_mem[w_rd_addr];
            end
        end
    end

endmodule

// File: tb/tb_screen_scaler_bridge.sv
// tb_screen_scaler_bridge: self-checking bench for screen_scaler_bridge (SCALE=2 main
// instance plus a SCALE=1 instance for geometry), with a behavioural source memory.
module tb_screen_scaler_bridge;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Main instance (SCALE=2)
    logic       tick, rd;
    logic [2:0] row;
    logic [6:0] col;
    logic [7:0] data;
    logic       ack, fdone, busy, sread;
    logic [7:0] sidx;
    logic [7:0] sbyte;
    logic       sack;

    // Geometry instance (SCALE=1)
    logic       tick1, rd1;
    logic [1:0] row1;
    logic [5:0] col1;
    logic [7:0] data1;
    logic       ack1, fdone1, busy1, sread1;
    logic [7:0] sidx1;
    logic [7:0] sbyte1;
    logic       sack1;

    screen_scaler_bridge #(.SRC_W(64), .SRC_H(32), .SCALE(2)) u_dut (
        .i_clk(clk), .i_reset(rst), .i_tick_60hz(tick), .i_read(rd),
        .i_row_idx(row), .i_column_idx(col), .o_data(data), .o_ack(ack),
        .o_frame_done(fdone), .o_scr_busy(busy), .o_scr_read(sread),
        .o_scr_read_idx(sidx), .i_scr_read_byte(sbyte), .i_scr_read_ack(sack)
    );

    screen_scaler_bridge #(.SRC_W(64), .SRC_H(32), .SCALE(1)) u_dut1 (
        .i_clk(clk), .i_reset(rst), .i_tick_60hz(tick1), .i_read(rd1),
        .i_row_idx(row1), .i_column_idx(col1), .o_data(data1), .o_ack(ack1),
        .o_frame_done(fdone1), .o_scr_busy(busy1), .o_scr_read(sread1),
        .o_scr_read_idx(sidx1), .i_scr_read_byte(sbyte1), .i_scr_read_ack(sack1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Source memories and responders (ack one cycle after request, plus optional stall).
    logic [7:0] src0 [256];
    logic [7:0] src1 [256];
    int stall = 0;
    int wait_cnt;
    logic [7:0] idx_log[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sack     <= 1'b0;
            sbyte    <= 8'h00;
            wait_cnt <= 0;
        end else begin
            sack <= 1'b0;
            if (sread && !sack) begin
                if (wait_cnt >= stall) begin
                    sack     <= 1'b1;
                    sbyte    <= src0[sidx];
                    wait_cnt <= 0;
                end else begin
                    wait_cnt <= wait_cnt + 1;
                end
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sack1  <= 1'b0;
            sbyte1 <= 8'h00;
        end else begin
            sack1 <= 1'b0;
            if (sread1 && !sack1) begin
                sack1  <= 1'b1;
                sbyte1 <= src1[sidx1];
                if (idx_log.size() < 4) idx_log.push_back(sidx1);
            end
        end
    end

    // Request stability monitor: an un-acked request must stay up with a fixed address.
    logic       mon_en = 1'b0;
    logic       prev_sread;
    logic [7:0] prev_idx;
    int stab_err = 0;
    int stall_cycles = 0;

    always @(negedge clk) begin
        if (mon_en && !rst && prev_sread) begin
            if (sidx !== prev_idx || !(sread || sack)) stab_err <= stab_err + 1;
            if (sread) stall_cycles <= stall_cycles + 1;
        end
        prev_sread <= sread && mon_en;
        prev_idx   <= sidx;
    end

    // Read scoreboard for the main instance.
    typedef struct packed {
        logic [7:0]  exp;
        logic [15:0] id;
    } sb_t;
    sb_t sb_q[$];
    sb_t sb_e;
    int  rd_id = 0;

    always @(negedge clk) begin
        if (!rst && ack) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_ack: got ack=1, expected no outstanding read");
            end else begin
                sb_e = sb_q.pop_front();
                check($sformatf("read_%0d", sb_e.id), data, sb_e.exp);
            end
        end
    end

    task automatic do_read(input int p, input int c, input logic [7:0] exp);
        sb_t e;
        rd  = 1'b1;
        row = 3'(p);
        col = 7'(c);
        e.exp = exp;
        e.id  = 16'(rd_id);
        rd_id++;
        sb_q.push_back(e);
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic drain(input string name);
        repeat (2) @(negedge clk);
        check({name, "_missing_ack"}, sb_q.size(), 0);
        sb_q.delete();
    endtask

    task automatic read1(input int p, input int c, input logic [7:0] exp, input string name);
        rd1  = 1'b1;
        row1 = 2'(p);
        col1 = 6'(c);
        @(negedge clk);
        rd1 = 1'b0;
        check({name, "_ack"}, ack1, 1);
        check(name, data1, exp);
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic wait_fdone(input int limit, input string name, output int cycles);
        cycles = 0;
        while (!fdone && cycles < limit) begin
            @(negedge clk);
            cycles++;
        end
        check({name, "_frame_done"}, fdone, 1);
    endtask

    // Reference conversion of src0 at SCALE=2.
    function automatic logic [7:0] model_byte(input int p, input int c);
        logic [7:0] r;
        logic [7:0] b8;
        int y;
        int x;
        r = 8'h00;
        for (int b = 0; b < 8; b++) begin
            y = (p * 8 + b) / 2;
            x = c / 2;
            b8 = src0[y * 8 + x / 8];
            r[b] = b8[7 - (x % 8)];
        end
        return r;
    endfunction

    typedef struct packed {
        logic [2:0] row;
        logic [6:0] col;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[5];
    int   rp[16];
    int   rc[16];
    int   cyc;
    int   pulses;

    initial begin
        vecs[0] = '{row: 3'd0, col: 7'd0,   exp: 8'h03};
        vecs[1] = '{row: 3'd0, col: 7'd1,   exp: 8'h03};
        vecs[2] = '{row: 3'd0, col: 7'd2,   exp: 8'h00};
        vecs[3] = '{row: 3'd1, col: 7'd0,   exp: 8'h00};
        vecs[4] = '{row: 3'd7, col: 7'd127, exp: 8'h00};

        rst = 1'b1; tick = 1'b0; rd = 1'b0; row = '0; col = '0;
        tick1 = 1'b0; rd1 = 1'b0; row1 = '0; col1 = '0;
        for (int i = 0; i < 256; i++) begin
            src0[i] = 8'h00;
            src1[i] = 8'h00;
        end
        src0[0]  = 8'h80;
        src1[56] = 8'h01;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Power-up conversion, single-pixel image.
        wait_fdone(4000, "powerup", cyc);
        check("powerup_latency", cyc, 1536);
        for (int i = 0; i < 5; i++) do_read(int'(vecs[i].row), int'(vecs[i].col), vecs[i].exp);
        drain("pixel");

        // SCALE=1 geometry.
        check("dut1_idle", busy1, 0);
        check("dut1_idx_log_size", idx_log.size(), 4);
        for (int i = 0; i < 4 && i < idx_log.size(); i++)
            check($sformatf("dut1_idx_%0d", i), idx_log[i], 8 * i);
        read1(0, 7, 8'h80, "dut1_p0c7");
        read1(0, 6, 8'h00, "dut1_p0c6");

        // Random image, then same image with a stalling source.
        for (int i = 0; i < 256; i++) src0[i] = 8'($urandom);
        for (int i = 0; i < 16; i++) begin
            rp[i] = $urandom_range(0, 7);
            rc[i] = $urandom_range(0, 127);
        end
        pulse_tick();
        wait_fdone(4000, "rand", cyc);
        check("tick_latency", cyc, 1537);
        for (int i = 0; i < 16; i++) do_read(rp[i], rc[i], model_byte(rp[i], rc[i]));
        drain("rand");

        stall = 5;
        mon_en = 1'b1;
        pulse_tick();
        wait_fdone(8000, "stall", cyc);
        mon_en = 1'b0;
        stall = 0;
        check("stall_stability", stab_err, 0);
        check("stall_seen", stall_cycles > 100, 1);
        for (int i = 0; i < 16; i++) do_read(rp[i], rc[i], model_byte(rp[i], rc[i]));
        drain("stall");

        // Three ticks during one conversion collapse into one further conversion.
        pulse_tick();
        repeat (100) @(negedge clk);
        pulse_tick();
        repeat (100) @(negedge clk);
        pulse_tick();
        wait_fdone(4000, "multi_a", cyc);
        check("multi_idle_at_done", busy, 0);
        @(negedge clk);
        check("multi_restart", busy, 1);
        wait_fdone(4000, "multi_b", cyc);
        pulses = 0;
        repeat (2000) begin
            @(negedge clk);
            if (fdone) pulses++;
        end
        check("multi_no_extra", pulses, 0);
        check("multi_final_idle", busy, 0);

        // Tick in the same cycle IDLE consumes the pending request wins.
        pulse_tick();
        repeat (100) @(negedge clk);
        pulse_tick();
        wait_fdone(4000, "coll_a", cyc);
        pulse_tick();
        check("coll_restart_a", busy, 1);
        wait_fdone(4000, "coll_b", cyc);
        @(negedge clk);
        check("coll_restart_b", busy, 1);
        wait_fdone(4000, "coll_c", cyc);
        pulses = 0;
        repeat (2000) begin
            @(negedge clk);
            if (fdone) pulses++;
        end
        check("coll_no_extra", pulses, 0);

        // Frame A (all set) then frame B (all clear).
        for (int i = 0; i < 256; i++) src0[i] = 8'hFF;
        pulse_tick();
        wait_fdone(4000, "frame_a", cyc);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 256; i++) src0[i] = 8'h00;
        pulse_tick();
        repeat (100) @(negedge clk);
`ifdef SCREEN_DOUBLE_BUFFER_EN
        do_read(0, 0, 8'hFF);
`else
        do_read(0, 0, 8'h00);
`endif
        do_read(7, 127, 8'hFF);
        wait_fdone(4000, "frame_b", cyc);
`ifdef SCREEN_DOUBLE_BUFFER_EN
        do_read(7, 127, 8'hFF);
`else
        do_read(7, 127, 8'h00);
`endif
        do_read(7, 127, 8'h00);
        do_read(0, 0, 8'h00);
        drain("dbuf");

        // Reset in the middle of WRITE.
        for (int i = 0; i < 256; i++) src0[i] = 8'hFF;
        pulse_tick();
        wait_fdone(4000, "pre_reset", cyc);
        do_read(3, 50, 8'hFF);
        drain("pre_reset");
        pulse_tick();
        cyc = 0;
        while (!(busy && !sread && !sack) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("reached_write", busy && !sread && !sack, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_ack", ack, 0);
        check("rst_data", data, 0);
        check("rst_frame_done", fdone, 0);
        check("rst_busy", busy, 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_scr_read", sread, 1);
        check("rel_scr_read_idx", sidx, 0);
        wait_fdone(4000, "post_reset", cyc);
        check("post_reset_latency", cyc, 1536);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
